// File: rtl/switch_out_buffer_pkg.sv
// Shared configuration for the switch output buffer: default widths, the
// valid-bit position inside a data word and the "port off" mux code.
package switch_out_buffer_pkg;

    localparam int         PATH_WIDTH_DEF = 32;
    localparam logic [3:0] CONF_OFF       = 4'b0000;

    // The valid flag sits directly above the payload.
    function automatic int valid_bit(input int path_width);
        return path_width;
    endfunction

    function automatic logic conf_is_on(input logic [3:0] conf);
        return conf != CONF_OFF;
    endfunction

endpackage

// File: rtl/switch_fifo.sv
// Synchronous DEPTH x WIDTH FIFO with combinational head read and
// occupancy-based full/empty; writes to a full FIFO are discarded.
module switch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_wr;
    logic             w_do_rd;

    assign full    = (r_count == CNT_W'(DEPTH));
    assign empty   = (r_count == '0);
    assign w_do_wr = wr_en && !full;
    assign w_do_rd = rd_en && !empty;
    assign rd_data = r_mem[r_rd_ptr];

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_do_wr && !w_do_rd) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_do_rd && !w_do_wr) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/switch_out_buffer.sv
// Credit-flow-controlled elastic buffer behind one switch output mux:
// buffers mux words, forwards them while downstream credits remain.
module switch_out_buffer
    import switch_out_buffer_pkg::*;
#(
    parameter int PATH_WIDTH = PATH_WIDTH_DEF,
    parameter int DEPTH      = 2,
    parameter int CREDITS    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          conf,
    input  logic [PATH_WIDTH:0] d_in,
    input  logic                credit_in,
    output logic [PATH_WIDTH:0] d_out,
    output logic                credit_out,
    output logic                ovf_err,
    output logic                crd_err
);

    localparam int VB    = valid_bit(PATH_WIDTH);
    localparam int CRD_W = $clog2(CREDITS) + 1;

    logic [CRD_W-1:0]      r_credit_cnt;
    logic [PATH_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;
    logic                  r_credit_out;
    logic                  r_ovf_err;
    logic                  r_crd_err;

    logic                  w_in_valid;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic                  w_have_credit;
    logic [PATH_WIDTH-1:0] w_head;

    assign w_in_valid    = d_in[VB] && conf_is_on(conf);
    // A full FIFO rejects the word even if the head leaves on the same edge.
    assign w_wr_en       = w_in_valid && !w_full;
    // A credit arriving this cycle can be spent on this cycle's forward.
    assign w_have_credit = (r_credit_cnt != '0) || credit_in;
    assign w_rd_en       = !w_empty && w_have_credit;

    switch_fifo #(
        .WIDTH (PATH_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr_en),
        .wr_data (d_in[PATH_WIDTH-1:0]),
        .rd_en   (w_rd_en),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credit_cnt <= CRD_W'(CREDITS);
            r_crd_err    <= 1'b0;
        end else if (credit_in && !w_rd_en) begin
            if (r_credit_cnt == CRD_W'(CREDITS)) begin
                r_crd_err <= 1'b1;
            end else begin
                r_credit_cnt <= r_credit_cnt + CRD_W'(1);
            end
        end else if (w_rd_en && !credit_in) begin
            r_credit_cnt <= r_credit_cnt - CRD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_credit_out <= 1'b0;
        end else begin
            r_out_valid  <= w_rd_en;
            r_credit_out <= w_rd_en;
            if (w_rd_en) begin
                r_out_data <= w_head;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf_err <= 1'b0;
        end else if (w_in_valid && w_full) begin
            r_ovf_err <= 1'b1;
        end
    end

    assign d_out      = {r_out_valid, r_out_data};
    assign credit_out = r_credit_out;
    assign ovf_err    = r_ovf_err;
    assign crd_err    = r_crd_err;

endmodule

// File: tb/tb_switch_out_buffer.sv
// Bench for switch_out_buffer: scenario tasks with inline checks plus a
// scoreboard monitor that pops expected payloads whenever d_out is valid.
module tb_switch_out_buffer;

    localparam int PW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    conf;
    logic [PW:0]   d_in;
    logic          credit_in;
    logic [PW:0]   d_out;
    logic          credit_out;
    logic          ovf_err;
    logic          crd_err;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] mon_exp;

    always #5 clk = ~clk;

    switch_out_buffer #(
        .PATH_WIDTH (PW),
        .DEPTH      (2),
        .CREDITS    (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .conf       (conf),
        .d_in       (d_in),
        .credit_in  (credit_in),
        .d_out      (d_out),
        .credit_out (credit_out),
        .ovf_err    (ovf_err),
        .crd_err    (crd_err)
    );

    // Scoreboard: every valid output word must match the oldest expected one.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            n_checks++;
            if (credit_out !== d_out[PW]) begin
                n_errors++;
                $display("FAIL sb_credit_pulse: credit_out=%b d_out_valid=%b", credit_out, d_out[PW]);
            end
            if (d_out[PW] === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL sb_unexpected: got %h, expected no word", d_out[PW-1:0]);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (d_out[PW-1:0] !== mon_exp) begin
                        n_errors++;
                        $display("FAIL sb_payload: got %h, expected %h", d_out[PW-1:0], mon_exp);
                    end
                end
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst       = 1'b1;
        conf      = 4'b0000;
        d_in      = '0;
        credit_in = 1'b0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        conf = 4'b0011;
        d_in = {1'b1, 32'h0000_0011};
        exp_q.push_back(32'h0000_0011);
        @(negedge clk);
        d_in = {1'b1, 32'h0000_0022};
        @(negedge clk);
        d_in = '0;
        n_checks++;
        if (dut.r_credit_cnt !== 2'd1) begin
            n_errors++;
            $display("FAIL rst_pre_credit: got %0d, expected 1", dut.r_credit_cnt);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (d_out !== '0 || credit_out !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_outputs: d_out=%h credit_out=%b, expected 0/0", d_out, credit_out);
        end
        n_checks++;
        if (ovf_err !== 1'b0 || crd_err !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_errors: ovf=%b crd=%b, expected 0/0", ovf_err, crd_err);
        end
        n_checks++;
        if (dut.r_credit_cnt !== 2'd2) begin
            n_errors++;
            $display("FAIL rst_credit: got %0d, expected 2", dut.r_credit_cnt);
        end
        @(negedge clk);
        rst  = 1'b0;
        d_in = {1'b1, 32'h0000_0033};
        exp_q.push_back(32'h0000_0033);
        @(negedge clk);
        d_in = '0;
        n_checks++;
        if (d_out[PW] !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_after_c1: valid=%b, expected 0", d_out[PW]);
        end
        @(negedge clk);
        n_checks++;
        if (d_out !== {1'b1, 32'h0000_0033}) begin
            n_errors++;
            $display("FAIL rst_after_c2: got %h, expected %h", d_out, {1'b1, 32'h0000_0033});
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL rst_drain: %0d words pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_single();
        apply_reset();
        conf = 4'b0011;
        d_in = {1'b1, 32'h0000_00A5};
        exp_q.push_back(32'h0000_00A5);
        @(negedge clk);
        d_in = '0;
        n_checks++;
        if (d_out[PW] !== 1'b0 || credit_out !== 1'b0) begin
            n_errors++;
            $display("FAIL single_c1: valid=%b credit_out=%b, expected 0/0", d_out[PW], credit_out);
        end
        @(negedge clk);
        n_checks++;
        if (d_out !== {1'b1, 32'h0000_00A5} || credit_out !== 1'b1) begin
            n_errors++;
            $display("FAIL single_c2: d_out=%h credit_out=%b, expected %h/1", d_out, credit_out, {1'b1, 32'h0000_00A5});
        end
        @(negedge clk);
        n_checks++;
        if (d_out[PW] !== 1'b0 || credit_out !== 1'b0) begin
            n_errors++;
            $display("FAIL single_c3: valid=%b credit_out=%b, expected 0/0", d_out[PW], credit_out);
        end
        n_checks++;
        if (dut.r_credit_cnt !== 2'd1) begin
            n_errors++;
            $display("FAIL single_credit: got %0d, expected 1", dut.r_credit_cnt);
        end
    endtask

    task automatic test_credit_stall();
        apply_reset();
        conf = 4'b0011;
        for (int i = 1; i <= 3; i++) begin
            d_in = {1'b1, PW'(i)};
            exp_q.push_back(PW'(i));
            @(negedge clk);
        end
        d_in = '0;
        n_checks++;
        if (d_out !== {1'b1, 32'h2}) begin
            n_errors++;
            $display("FAIL stall_c3: got %h, expected %h", d_out, {1'b1, 32'h2});
        end
        @(negedge clk);
        n_checks++;
        if (dut.r_credit_cnt !== 2'd0) begin
            n_errors++;
            $display("FAIL stall_credit0: got %0d, expected 0", dut.r_credit_cnt);
        end
        @(negedge clk);
        @(negedge clk);
        credit_in = 1'b1;
        n_checks++;
        if (d_out[PW] !== 1'b0) begin
            n_errors++;
            $display("FAIL stall_held: valid=%b, expected 0", d_out[PW]);
        end
        @(negedge clk);
        credit_in = 1'b0;
        n_checks++;
        if (d_out !== {1'b1, 32'h3}) begin
            n_errors++;
            $display("FAIL stall_c7: got %h, expected %h", d_out, {1'b1, 32'h3});
        end
        @(negedge clk);
        n_checks++;
        if (d_out[PW] !== 1'b0 || ovf_err !== 1'b0 || crd_err !== 1'b0) begin
            n_errors++;
            $display("FAIL stall_c8: valid=%b ovf=%b crd=%b, expected 0/0/0", d_out[PW], ovf_err, crd_err);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        conf = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            d_in = {1'b1, 32'h100 + PW'(i)};
            exp_q.push_back(32'h100 + PW'(i));
            @(negedge clk);
        end
        d_in = {1'b1, 32'h0000_DEAD};
        n_checks++;
        if (ovf_err !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_before: got %b, expected 0", ovf_err);
        end
        @(negedge clk);
        d_in = '0;
        n_checks++;
        if (ovf_err !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_set: got %b, expected 1", ovf_err);
        end
        @(negedge clk);
        @(negedge clk);
        // Full FIFO with a same-cycle forward: this word must still be dropped.
        d_in      = {1'b1, 32'h0000_BEEF};
        credit_in = 1'b1;
        n_checks++;
        if (ovf_err !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_sticky: got %b, expected 1", ovf_err);
        end
        @(negedge clk);
        d_in = '0;
        n_checks++;
        if (d_out !== {1'b1, 32'h102}) begin
            n_errors++;
            $display("FAIL ovf_first: got %h, expected %h", d_out, {1'b1, 32'h102});
        end
        @(negedge clk);
        n_checks++;
        if (d_out !== {1'b1, 32'h103}) begin
            n_errors++;
            $display("FAIL ovf_second: got %h, expected %h", d_out, {1'b1, 32'h103});
        end
        @(negedge clk);
        credit_in = 1'b0;
        n_checks++;
        if (d_out[PW] !== 1'b0 || crd_err !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_drained: valid=%b crd=%b, expected 0/0", d_out[PW], crd_err);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL ovf_queue: %0d words pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_port_off();
        apply_reset();
        conf = 4'b0000;
        d_in = {1'b1, 32'h55};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (d_out[PW] !== 1'b0 || credit_out !== 1'b0) begin
                n_errors++;
                $display("FAIL off_cycle%0d: valid=%b credit_out=%b, expected 0/0", i, d_out[PW], credit_out);
            end
        end
        d_in = '0;
        conf = 4'b0011;
        repeat (3) @(negedge clk);
        n_checks++;
        if (d_out[PW] !== 1'b0) begin
            n_errors++;
            $display("FAIL off_nothing_stored: valid=%b, expected 0", d_out[PW]);
        end
        d_in = {1'b1, 32'h66};
        exp_q.push_back(32'h66);
        @(negedge clk);
        conf = 4'b0000;
        d_in = {1'b1, 32'h77};
        @(negedge clk);
        d_in = '0;
        n_checks++;
        if (d_out !== {1'b1, 32'h66}) begin
            n_errors++;
            $display("FAIL off_drain: got %h, expected %h", d_out, {1'b1, 32'h66});
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (d_out[PW] !== 1'b0 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL off_ignored: valid=%b pending=%0d, expected 0/0", d_out[PW], exp_q.size());
        end
    endtask

    task automatic test_credit_boundary();
        apply_reset();
        conf      = 4'b0011;
        credit_in = 1'b1;
        @(negedge clk);
        credit_in = 1'b0;
        n_checks++;
        if (crd_err !== 1'b1 || dut.r_credit_cnt !== 2'd2) begin
            n_errors++;
            $display("FAIL crd_saturate: crd=%b cnt=%0d, expected 1/2", crd_err, dut.r_credit_cnt);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (crd_err !== 1'b1) begin
            n_errors++;
            $display("FAIL crd_sticky: got %b, expected 1", crd_err);
        end
        apply_reset();
        conf = 4'b0011;
        d_in = {1'b1, 32'hC1};
        exp_q.push_back(32'hC1);
        @(negedge clk);
        d_in = {1'b1, 32'hC2};
        exp_q.push_back(32'hC2);
        @(negedge clk);
        d_in      = '0;
        credit_in = 1'b1;
        n_checks++;
        if (dut.r_credit_cnt !== 2'd1) begin
            n_errors++;
            $display("FAIL crd_pre: got %0d, expected 1", dut.r_credit_cnt);
        end
        @(negedge clk);
        credit_in = 1'b0;
        n_checks++;
        if (dut.r_credit_cnt !== 2'd1 || crd_err !== 1'b0) begin
            n_errors++;
            $display("FAIL crd_same_cycle: cnt=%0d crd=%b, expected 1/0", dut.r_credit_cnt, crd_err);
        end
        n_checks++;
        if (d_out !== {1'b1, 32'hC2}) begin
            n_errors++;
            $display("FAIL crd_word: got %h, expected %h", d_out, {1'b1, 32'hC2});
        end
    endtask

    task automatic test_back_to_back();
        logic [PW-1:0] payload;
        apply_reset();
        conf = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            if (i < 6) begin
                payload = PW'($urandom);
                d_in    = {1'b1, payload};
                exp_q.push_back(payload);
            end else begin
                d_in = '0;
            end
            credit_in = (i >= 3 && i <= 6);
            if (i >= 2) begin
                n_checks++;
                if (d_out[PW] !== 1'b1) begin
                    n_errors++;
                    $display("FAIL b2b_valid_c%0d: got %b, expected 1", i, d_out[PW]);
                end
            end
            @(negedge clk);
        end
        credit_in = 1'b0;
        n_checks++;
        if (d_out[PW] !== 1'b0 || dut.r_credit_cnt !== 2'd0 || crd_err !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_end: valid=%b cnt=%0d crd=%b, expected 0/0/0", d_out[PW], dut.r_credit_cnt, crd_err);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL b2b_queue: %0d words pending, expected 0", exp_q.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        conf      = 4'b0000;
        d_in      = '0;
        credit_in = 1'b0;
        test_reset();
        test_single();
        test_credit_stall();
        test_overflow();
        test_port_off();
        test_credit_boundary();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
